// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback and
// drives datapath mux selects and write strobes from the current state.
module main_fsm (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t cur;

    assign state = cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur <= S_FETCH;
        end else begin
            case (cur)
                S_FETCH:    cur <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: cur <= S_MEMADR;
                        OP_R:         cur <= S_EXECUTER;
                        OP_I:         cur <= S_EXECUTEI;
                        OP_BEQ:       cur <= S_BEQ;
                        OP_JAL:       cur <= S_JAL;
                        default:      cur <= S_FETCH;
                    endcase
                end
                // op is stable from DECODE, but fall back to FETCH if it is not a memory op
                S_MEMADR: begin
                    if (op == OP_LW)      cur <= S_MEMREAD;
                    else if (op == OP_SW) cur <= S_MEMWRITE;
                    else                  cur <= S_FETCH;
                end
                S_MEMREAD:  cur <= mem_ready ? S_MEMWB : S_MEMREAD;
                S_MEMWRITE: cur <= mem_ready ? S_FETCH : S_MEMWRITE;
                S_EXECUTER, S_EXECUTEI, S_JAL: cur <= S_ALUWB;
                default:    cur <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        ALUOp     = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        case (cur)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // one-shot per fetch: only the completing cycle writes IR and PC
                IRWrite   = mem_ready & reset_n;
                PCUpdate  = mem_ready & reset_n;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
